// File: rtl/fact_bus_if.sv
// Memory-mapped front end for the factorial peripheral.
// Holds the operand, issues a one-cycle start pulse to the core, tracks
// busy/done/error status and latches the core product for software readback.
module fact_bus_if #(
   parameter int DATA_W = 32,
   parameter int N_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   output logic [N_W-1:0]    core_n,
   output logic              core_go,
   input  logic              core_done,
   input  logic              core_error,
   input  logic [DATA_W-1:0] core_result
);

   localparam logic [1:0] A_N      = 2'd0;
   localparam logic [1:0] A_GO     = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_RESULT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GO   = 2'd1,
      S_WAIT = 2'd2,
      S_CAPT = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N_W-1:0]    n_q;
   logic [DATA_W-1:0] res_q;
   logic              done_f;
   logic              err_f;
   logic              busy;
   logic              go_acc;
   logic              n_wr;

   // Bus writes only take effect while idle; anything else is silently dropped
   assign go_acc = we && (addr == A_GO) && wd[0] && (state == S_IDLE);
   assign n_wr   = we && (addr == A_N) && (state == S_IDLE);

   assign core_n = n_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; core_done is only looked at in WAIT since the core
   // also reports done while it is idle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (go_acc) state_nxt = S_GO;
         S_GO:   state_nxt = core_error ? S_IDLE : S_WAIT;
         S_WAIT: if (core_done) state_nxt = S_CAPT;
         S_CAPT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs: start pulse in GO only, busy whenever not idle
   always_comb begin
      core_go = 1'b0;
      busy    = 1'b1;
      case (state)
         S_IDLE: busy    = 1'b0;
         S_GO:   core_go = 1'b1;
         default: ;
      endcase
   end

   // Operand register, writable only while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q <= '0;
      end else if (n_wr) begin
         n_q <= wd[N_W-1:0];
      end
   end

   // Sticky done/error flags and result capture; an accepted GO clears flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q  <= '0;
         done_f <= 1'b0;
         err_f  <= 1'b0;
      end else begin
         if (go_acc) begin
            done_f <= 1'b0;
            err_f  <= 1'b0;
         end else if ((state == S_GO) && core_error) begin
            done_f <= 1'b1;
            err_f  <= 1'b1;
         end else if (state == S_CAPT) begin
            res_q  <= core_result;
            done_f <= 1'b1;
            err_f  <= 1'b0;
         end
      end
   end

   // Combinational read mux; unused bits read as zero
   always_comb begin
      rd = '0;
      case (addr)
         A_N:      rd[N_W-1:0] = n_q;
         A_GO:     rd = '0;
         A_STATUS: rd[2:0] = {busy, err_f, done_f};
         A_RESULT: rd = res_q;
         default:  rd = '0;
      endcase
   end

endmodule

// File: tb/tb_fact_bus_if.sv
// Bench for fact_bus_if with a simple behavioural factorial core model.
module tb_fact_bus_if;

   localparam int DATA_W = 32;
   localparam int N_W    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we = 1'b0;
   logic [1:0]        addr = 2'd0;
   logic [DATA_W-1:0] wd = '0;
   logic [DATA_W-1:0] rd;
   logic [N_W-1:0]    core_n;
   logic              core_go;
   logic              core_done;
   logic              core_error;
   logic [DATA_W-1:0] core_result;

   fact_bus_if #(.DATA_W(DATA_W), .N_W(N_W)) dut (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
      .core_n(core_n), .core_go(core_go), .core_done(core_done),
      .core_error(core_error), .core_result(core_result)
   );

   always #5 clk = ~clk;

   // Core model: out of range above 12!, compute time of max(n,1) cycles,
   // done while idle, garbage on the product while computing
   logic        c_busy;
   int          c_cnt;
   logic [31:0] c_prod;

   function automatic logic [31:0] fact(input int n);
      logic [31:0] p = 32'd1;
      for (int i = 2; i <= n; i++) p = p * 32'(i);
      return p;
   endfunction

   assign core_error  = (core_n > 4'd12);
   assign core_done   = !c_busy;
   assign core_result = c_busy ? 32'hDEAD_BEEF : c_prod;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_busy <= 1'b0;
         c_cnt  <= 0;
         c_prod <= 32'd1;
      end else if (core_go && !core_error) begin
         c_busy <= 1'b1;
         c_cnt  <= (core_n == '0) ? 1 : int'(core_n);
         c_prod <= fact(int'(core_n));
      end else if (c_busy) begin
         if (c_cnt == 1) c_busy <= 1'b0;
         else c_cnt <= c_cnt - 1;
      end
   end

   int go_cnt = 0;
   always @(posedge clk) if (core_go) go_cnt <= go_cnt + 1;

   int          checks = 0;
   int          errors = 0;
   logic        rd_req = 1'b0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the expected read value whenever a read is presented
   initial forever begin
      @(negedge clk);
      if (rd_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got 0x%0h expected none", rd);
         end else begin
            check(name_q.pop_front(), rd, exp_q.pop_front());
         end
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      addr = a; wd = d; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0; wd = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
      addr = a;
      exp_q.push_back(e);
      name_q.push_back(nm);
      rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic idle_cycles(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input string nm);
      logic ok = 1'b0;
      addr = 2'd2;
      #1;
      for (int i = 0; i < 60; i++) begin
         if (rd[2] == 1'b0) begin ok = 1'b1; break; end
         @(posedge clk); #2;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: busy still 1 after 60 cycles, required 0", nm);
      end
      @(posedge clk); #1;
   endtask

   int g0;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      bus_read(2'd2, 32'd0, "rst_status");
      bus_read(2'd3, 32'd0, "rst_result");
      bus_read(2'd0, 32'd0, "rst_n");
      check("rst_core_go", {31'b0, core_go}, 32'd0);

      // Normal run: 5! = 120
      bus_write(2'd0, 32'd5);
      bus_read(2'd0, 32'd5, "n_readback");
      g0 = go_cnt;
      bus_write(2'd1, 32'd1);
      check("go_pulse_high", {31'b0, core_go}, 32'd1);
      bus_read(2'd2, 32'd4, "status_busy_in_go");
      check("go_pulse_low", {31'b0, core_go}, 32'd0);
      wait_idle("normal_idle");
      check("normal_go_count", 32'(go_cnt - g0), 32'd1);
      bus_read(2'd2, 32'd1, "normal_status");
      bus_read(2'd3, 32'd120, "normal_result");

      // Busy protection: N and GO writes during WAIT are dropped
      g0 = go_cnt;
      bus_write(2'd1, 32'd1);
      idle_cycles(1);
      bus_write(2'd0, 32'd3);
      bus_write(2'd1, 32'd1);
      wait_idle("busy_idle");
      check("busy_go_count", 32'(go_cnt - g0), 32'd1);
      bus_read(2'd0, 32'd5, "busy_n_kept");
      bus_read(2'd3, 32'd120, "busy_result");
      bus_read(2'd2, 32'd1, "busy_status");

      // Error: 13 is out of range, result keeps 120
      bus_write(2'd0, 32'd13);
      bus_read(2'd0, 32'd13, "n13_readback");
      g0 = go_cnt;
      bus_write(2'd1, 32'd1);
      idle_cycles(1);
      bus_read(2'd2, 32'd3, "err_status");
      bus_read(2'd3, 32'd120, "err_result_kept");
      check("err_go_count", 32'(go_cnt - g0), 32'd1);

      // Back-to-back: 0! = 1, flags cleared by the accepted GO
      bus_write(2'd0, 32'd0);
      bus_write(2'd1, 32'd1);
      bus_read(2'd2, 32'd4, "b2b_flags_cleared");
      wait_idle("b2b_idle");
      bus_read(2'd3, 32'd1, "b2b_result");
      bus_read(2'd2, 32'd1, "b2b_status");

      // GO written during CAPT is ignored: 3! = 6
      bus_write(2'd0, 32'd3);
      g0 = go_cnt;
      bus_write(2'd1, 32'd1);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (core_done) begin seen = 1'b1; break; end
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL capt_wait_done: core_done still 0 after 60 cycles, required 1");
         end
      end
      @(posedge clk); #1;
      bus_write(2'd1, 32'd1);
      bus_read(2'd2, 32'd1, "capt_go_ignored_status");
      check("capt_go_count", 32'(go_cnt - g0), 32'd1);
      bus_read(2'd3, 32'd6, "capt_result");

      // Read map
      bus_read(2'd1, 32'd0, "go_reads_zero");
      bus_write(2'd0, 32'hFFFF_FFFA);
      bus_read(2'd0, 32'h0000_000A, "n_zero_ext");

      // Asynchronous reset in the middle of WAIT
      bus_write(2'd0, 32'd7);
      bus_write(2'd1, 32'd1);
      idle_cycles(2);
      addr = 2'd2;
      #1 rst = 1'b1;
      #1 check("async_rst_status", rd, 32'd0);
      check("async_rst_core_go", {31'b0, core_go}, 32'd0);
      addr = 2'd3;
      #1 check("async_rst_result", rd, 32'd0);
      addr = 2'd0;
      #1 check("async_rst_n", rd, 32'd0);
      @(posedge clk); #1;
      bus_read(2'd2, 32'd0, "rst_held_status");
      rst = 1'b0;
      bus_read(2'd0, 32'd0, "post_rst_n");

      // Recovery after reset: 4! = 24
      bus_write(2'd0, 32'd4);
      bus_write(2'd1, 32'd1);
      wait_idle("recover_idle");
      bus_read(2'd3, 32'd24, "recover_result");
      bus_read(2'd2, 32'd1, "recover_status");

      @(posedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
